// File: rtl/ddr_a2m_reqarb_pkg.sv
// Shared definitions for the AXI address-channel request arbiter and its queue.
// Entry layout, LSB first: id, addr, len, size, burst, lock, dir.
package ddr_a2m_reqarb_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic DIR_WR = 1'b1;
    localparam logic DIR_RD = 1'b0;

    function automatic int entry_w(input int iw, input int aw);
        return iw + aw + 15;
    endfunction

    function automatic int off_addr(input int iw);
        return iw;
    endfunction

    function automatic int off_len(input int iw, input int aw);
        return iw + aw;
    endfunction

    function automatic int off_size(input int iw, input int aw);
        return iw + aw + 8;
    endfunction

    function automatic int off_burst(input int iw, input int aw);
        return iw + aw + 11;
    endfunction

    function automatic int off_lock(input int iw, input int aw);
        return iw + aw + 13;
    endfunction

    function automatic int off_dir(input int iw, input int aw);
        return iw + aw + 14;
    endfunction

endpackage

// File: rtl/ddr_a2m_reqfifo.sv
// In-order request queue: storage, wrap-bit pointers, EMPTY/full and a
// registered output that only changes on a valid pop.
module ddr_a2m_reqfifo
    import ddr_a2m_reqarb_pkg::*;
#(
    parameter int P_W   = 63,
    parameter int P_QDW = 2
) (
    input  logic             CLK,
    input  logic             ZRESET,
    input  logic             push,
    input  logic [P_W-1:0]   din,
    input  logic             re,
    output logic             empty,
    output logic             full,
    output logic [P_W-1:0]   dout
);

    localparam int DEPTH = 2 ** P_QDW;

    logic [P_QDW:0] wptr;
    logic [P_QDW:0] rptr;
    logic [P_W-1:0] mem [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[P_QDW] != rptr[P_QDW]) &&
                   (wptr[P_QDW-1:0] == rptr[P_QDW-1:0]);

    // No bypass: a full queue refuses the push even when a pop frees a slot.
    assign do_push = push & ~full;
    assign do_pop  = re & ~empty;

    always_ff @(posedge CLK or negedge ZRESET) begin
        if (!ZRESET) begin
            wptr <= '0;
            rptr <= '0;
            dout <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
                dout <= mem[rptr[P_QDW-1:0]];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wptr[P_QDW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ddr_a2m_reqarb.sv
// AW/AR arbitration into a single in-order request queue.
// Define DDR_A2M_REQARB_RR_EN for round-robin W/R priority; otherwise reads win ties.
module ddr_a2m_reqarb
    import ddr_a2m_reqarb_pkg::*;
#(
    parameter int P_IW  = 8,
    parameter int P_AW  = 40,
    parameter int P_QDW = 2
) (
    input  logic            CLK,
    input  logic            ZRESET,
    input  logic [P_IW-1:0] AWID,
    input  logic [P_AW-1:0] AWADDR,
    input  logic [7:0]      AWLEN,
    input  logic [2:0]      AWSIZE,
    input  logic [1:0]      AWBURST,
    input  logic            AWLOCK,
    input  logic            AWVALID,
    output logic            AWREADY,
    input  logic [P_IW-1:0] ARID,
    input  logic [P_AW-1:0] ARADDR,
    input  logic [7:0]      ARLEN,
    input  logic [2:0]      ARSIZE,
    input  logic [1:0]      ARBURST,
    input  logic            ARLOCK,
    input  logic            ARVALID,
    output logic            ARREADY,
    input  logic            RE,
    output logic            EMPTY,
    output logic [P_IW-1:0] AXID,
    output logic [P_AW-1:0] AXADDR,
    output logic [7:0]      AXLEN,
    output logic [2:0]      AXSIZE,
    output logic [1:0]      AXBURST,
    output logic            AXLOCK,
    output logic            AXDIR
);

    localparam int EW      = entry_w(P_IW, P_AW);
    localparam int O_ADDR  = off_addr(P_IW);
    localparam int O_LEN   = off_len(P_IW, P_AW);
    localparam int O_SIZE  = off_size(P_IW, P_AW);
    localparam int O_BURST = off_burst(P_IW, P_AW);
    localparam int O_LOCK  = off_lock(P_IW, P_AW);
    localparam int O_DIR   = off_dir(P_IW, P_AW);

    logic          rdy_en;
    logic          prio_w;
    logic          grant_w;
    logic          grant_r;
    logic          full;
    logic          aw_hs;
    logic          ar_hs;
    logic [EW-1:0] din;
    logic [EW-1:0] dout;

    // Holds READY low for the first cycle after reset release.
    always_ff @(posedge CLK or negedge ZRESET) begin
        if (!ZRESET) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

`ifdef DDR_A2M_REQARB_RR_EN
    always_ff @(posedge CLK or negedge ZRESET) begin
        if (!ZRESET) begin
            prio_w <= 1'b0;
        end else if (aw_hs) begin
            prio_w <= 1'b0;
        end else if (ar_hs) begin
            prio_w <= 1'b1;
        end
    end
`else
    assign prio_w = 1'b0;
`endif

    assign grant_w = AWVALID & (~ARVALID | prio_w);
    assign grant_r = ARVALID & ~grant_w;

    assign AWREADY = rdy_en & ~full & grant_w;
    assign ARREADY = rdy_en & ~full & grant_r;

    assign aw_hs = AWVALID & AWREADY;
    assign ar_hs = ARVALID & ARREADY;

    assign din = grant_w ? {DIR_WR, AWLOCK, AWBURST, AWSIZE, AWLEN, AWADDR, AWID}
                         : {DIR_RD, ARLOCK, ARBURST, ARSIZE, ARLEN, ARADDR, ARID};

    ddr_a2m_reqfifo #(
        .P_W   (EW),
        .P_QDW (P_QDW)
    ) u_fifo (
        .CLK    (CLK),
        .ZRESET (ZRESET),
        .push   (aw_hs | ar_hs),
        .din    (din),
        .re     (RE),
        .empty  (EMPTY),
        .full   (full),
        .dout   (dout)
    );

    assign AXID    = dout[0 +: P_IW];
    assign AXADDR  = dout[O_ADDR +: P_AW];
    assign AXLEN   = dout[O_LEN +: 8];
    assign AXSIZE  = dout[O_SIZE +: 3];
    assign AXBURST = dout[O_BURST +: 2];
    assign AXLOCK  = dout[O_LOCK];
    assign AXDIR   = dout[O_DIR];

endmodule
